// File: rtl/seg_scan_controller.sv
// Four-digit seven-segment scan scheduler with guard gaps, hex decode and frame-aligned double buffering.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always lit).
module seg_scan_controller #(
    parameter int DIV   = 100000,
    parameter int GUARD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    output logic [6:0]  segments,
    output logic [3:0]  anodes,
    output logic [1:0]  digit_idx,
    output logic        frame_tick
);

    localparam int CNT_MAX = (DIV > GUARD) ? DIV : GUARD;
    localparam int CW      = $clog2(CNT_MAX + 32'sd1);

    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(32'd1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 32'sd1);
    localparam logic [CW-1:0] GUARD_LAST = (GUARD > 32'sd0) ? CW'(GUARD - 32'sd1) : {CW{1'b0}};
    localparam logic          HAS_GUARD  = (GUARD > 32'sd0);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        nxt_state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] nxt_cnt_s;
    logic [1:0]    idx_r;
    logic [1:0]    nxt_idx_s;
    logic [15:0]   shown_r;
    logic [15:0]   nxt_shown_s;
    logic [15:0]   pending_r;
    logic          wr_ready_r;
    logic          commit_s;
    logic          lit_s;
    logic          nxt_tick_s;
    logic [3:0]    nxt_nibble_s;
    logic [6:0]    segments_r;
    logic [3:0]    anodes_r;
    logic          frame_tick_r;

    // Active-low hex patterns, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // True when digit idx and every more-significant nibble are zero; digit 0 never qualifies.
    function automatic logic leading_zero(input logic [1:0] idx, input logic [15:0] val);
        logic z;
        case (idx)
            2'd3:    z = (val[15:12] == 4'h0);
            2'd2:    z = (val[15:8]  == 8'h00);
            2'd1:    z = (val[15:4]  == 12'h000);
            default: z = 1'b0;
        endcase
        return z;
    endfunction
`endif

    // Slot sequencing: next state, slot counter and digit index.
    always_comb begin
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r;
        nxt_idx_s   = idx_r;
        if (!enable) begin
            nxt_state_s = ST_OFF;
            nxt_cnt_s   = CNT_ZERO;
            nxt_idx_s   = 2'd0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    nxt_state_s = HAS_GUARD ? ST_GUARD : ST_SHOW;
                    nxt_cnt_s   = CNT_ZERO;
                    nxt_idx_s   = 2'd0;
                end
                ST_GUARD: begin
                    if (cnt_r == GUARD_LAST) begin
                        nxt_state_s = ST_SHOW;
                        nxt_cnt_s   = CNT_ZERO;
                    end else begin
                        nxt_cnt_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_SHOW: begin
                    if (cnt_r == DIV_LAST) begin
                        nxt_state_s = HAS_GUARD ? ST_GUARD : ST_SHOW;
                        nxt_cnt_s   = CNT_ZERO;
                        nxt_idx_s   = idx_r + 2'd1;
                    end else begin
                        nxt_cnt_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    nxt_state_s = ST_OFF;
                    nxt_cnt_s   = CNT_ZERO;
                    nxt_idx_s   = 2'd0;
                end
            endcase
        end
    end

    // Buffer commit and next-cycle output values; frame_tick is looked ahead so it lands on the last lit cycle.
    always_comb begin
        commit_s = ~wr_ready_r &
                   ((state_r == ST_OFF) | ((state_r == ST_SHOW) & frame_tick_r & enable));
        if (commit_s) begin
            nxt_shown_s = pending_r;
        end else begin
            nxt_shown_s = shown_r;
        end
        nxt_nibble_s = nxt_shown_s[{nxt_idx_s, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        lit_s = (nxt_state_s == ST_SHOW) & ~leading_zero(nxt_idx_s, nxt_shown_s);
`else
        lit_s = (nxt_state_s == ST_SHOW);
`endif
        nxt_tick_s = (nxt_state_s == ST_SHOW) & (nxt_idx_s == 2'd3) & (nxt_cnt_s == DIV_LAST);
    end

    // State, buffers, handshake and registered display outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_OFF;
            cnt_r        <= CNT_ZERO;
            idx_r        <= 2'd0;
            shown_r      <= 16'h0000;
            pending_r    <= 16'h0000;
            wr_ready_r   <= 1'b1;
            segments_r   <= 7'h7F;
            anodes_r     <= 4'hF;
            frame_tick_r <= 1'b0;
        end else begin
            state_r      <= nxt_state_s;
            cnt_r        <= nxt_cnt_s;
            idx_r        <= nxt_idx_s;
            shown_r      <= nxt_shown_s;
            frame_tick_r <= nxt_tick_s;
            if (lit_s) begin
                anodes_r   <= ~(4'b0001 << nxt_idx_s);
                segments_r <= hex_decode(nxt_nibble_s);
            end else begin
                anodes_r   <= 4'hF;
                segments_r <= 7'h7F;
            end
            if (commit_s) begin
                wr_ready_r <= 1'b1;
            end else if (wr_en && wr_ready_r) begin
                pending_r  <= wr_data;
                wr_ready_r <= 1'b0;
            end else begin
                wr_ready_r <= wr_ready_r;
            end
        end
    end

    assign wr_ready   = wr_ready_r;
    assign segments   = segments_r;
    assign anodes     = anodes_r;
    assign digit_idx  = idx_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed scoreboard bench for seg_scan_controller with DIV=4, GUARD=2.
module tb_seg_scan_controller;

    localparam int DIV   = 4;
    localparam int GUARD = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic [6:0]  segments;
    logic [3:0]  anodes;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] idx;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    seg_scan_controller #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .segments   (segments),
        .anodes     (anodes),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic ref_lit(input int d, input logic [15:0] v);
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 0) return 1'b1;
        return ((v >> (4 * d)) != 16'h0000);
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Expected per-cycle output stream for one full frame showing value v.
    task automatic push_frame(input logic [15:0] v);
        exp_t e;
        logic [15:0] sh;
        for (int d = 0; d < 4; d++) begin
            for (int g = 0; g < GUARD; g++) begin
                e.an = 4'hF; e.seg = 7'h7F; e.idx = 2'(d); e.tick = 1'b0;
                q.push_back(e);
            end
            sh = v >> (4 * d);
            for (int k = 0; k < DIV; k++) begin
                if (ref_lit(d, v)) begin
                    e.an  = ~(4'b0001 << d);
                    e.seg = ref_seg(sh[3:0]);
                end else begin
                    e.an  = 4'hF;
                    e.seg = 7'h7F;
                end
                e.idx  = 2'(d);
                e.tick = (d == 3) && (k == DIV - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic steps(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("scan", {18'd0, anodes, segments, digit_idx, frame_tick}, {18'd0, e});
            end else begin
                check("scan_queue_empty", 32'd0, 32'd1);
            end
        end
    endtask

    task automatic check_blank(input string tag);
        check(tag, {20'd0, anodes, segments, digit_idx, frame_tick}, {20'd0, 4'hF, 7'h7F, 2'd0, 1'b0});
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_data = 16'h0000;
        @(negedge clk);
        check_blank("reset_outputs");
        check("reset_wr_ready", {31'd0, wr_ready}, 32'd1);

        // Release reset, start scanning; write 1234 while digit 1 is lit.
        @(negedge clk);
        reset = 1'b1; enable = 1'b1;
        push_frame(16'h0000); push_frame(16'h1234); push_frame(16'h1234);
        steps(9);
        wr_en = 1'b1; wr_data = 16'h1234;
        steps(1);
        wr_en = 1'b0;
        check("wr_ready_after_capture", {31'd0, wr_ready}, 32'd0);
        wr_en = 1'b1; wr_data = 16'hFFFF;
        steps(1);
        wr_en = 1'b0;
        check("wr_ready_after_drop", {31'd0, wr_ready}, 32'd0);
        steps(13);
        check("wr_ready_commit_cycle", {31'd0, wr_ready}, 32'd0);
        wr_en = 1'b1; wr_data = 16'hABCD;
        steps(1);
        wr_en = 1'b0;
        check("wr_ready_after_commit", {31'd0, wr_ready}, 32'd1);
        steps(47);

        // Disable while digit 2 is lit.
        push_frame(16'h1234);
        steps(15);
        enable = 1'b0;
        q.delete();
        @(negedge clk);
        check_blank("disable_blank");
        @(negedge clk);
        check_blank("off_hold");

        // Write while off commits on the cycle after capture.
        wr_en = 1'b1; wr_data = 16'h5678;
        @(negedge clk);
        wr_en = 1'b0;
        check("off_wr_ready_low", {31'd0, wr_ready}, 32'd0);
        @(negedge clk);
        check("off_wr_ready_high", {31'd0, wr_ready}, 32'd1);
        enable = 1'b1;
        push_frame(16'h5678);
        steps(24);

        // Reset asserted while digit 1 is lit.
        push_frame(16'h5678);
        steps(9);
        #2 reset = 1'b0;
        #1;
        check_blank("reset_async_blank");
        check("reset_async_wr_ready", {31'd0, wr_ready}, 32'd1);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        push_frame(16'h0000);
        steps(24);

        // Leading-digit patterns 0042 and 0000.
        enable = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 16'h0042;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        push_frame(16'h0042);
        steps(24);
        enable = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 16'h0000;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        push_frame(16'h0000);
        steps(24);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
